// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointer crossing, threshold flags and per-domain fill counts.
// Optional first-word-fall-through output stage: define FIFO_FWFT_EN.
module async_fifo_gray #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 6,
    parameter int AEMPTY_TH   = 1
) (
    input  logic              wclk,
    input  logic              rclk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_count,
    output logic              overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = ADDR_W + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [PW-1:0] wbin, wgray, wbin_nx, wgray_nx, rsync_bin, wcnt_nx;
    logic [SYNC_STAGES-1:0][PW-1:0] rsync_q;
    logic [PW-1:0] rgray_w;
    logic wr_ok;

    assign rgray_w   = rsync_q[SYNC_STAGES-1];
    assign wr_ok     = wr_en && !full;
    assign wbin_nx   = wbin + PW'(wr_ok);
    assign wgray_nx  = bin2gray(wbin_nx);
    assign rsync_bin = gray2bin(rgray_w);
    assign wr_count  = wbin - rsync_bin;
    assign wcnt_nx   = wbin_nx - rsync_bin;

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            rsync_q     <= '0;
            wbin        <= '0;
            wgray       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            rsync_q     <= {rsync_q[SYNC_STAGES-2:0], rgray};
            wbin        <= wbin_nx;
            wgray       <= wgray_nx;
            // Full when the write pointer is one lap ahead of the (stale) read pointer.
            full        <= (wgray_nx == {~rgray_w[PW-1:PW-2], rgray_w[PW-3:0]});
            almost_full <= (wcnt_nx >= PW'(AFULL_TH));
            overflow    <= wr_en && full;
        end
    end

    always_ff @(posedge wclk) begin
        if (wr_ok) mem[wbin[ADDR_W-1:0]] <= wdata;
    end

    // ---------------- read domain ----------------
    logic [PW-1:0] rbin, rgray, rbin_nx, rgray_nx, wsync_bin, rcnt_nx;
    logic [SYNC_STAGES-1:0][PW-1:0] wsync_q;
    logic [PW-1:0] wgray_r;
    logic ram_empty, rd_pull;

    assign wgray_r   = wsync_q[SYNC_STAGES-1];
    assign wsync_bin = gray2bin(wgray_r);
    assign rbin_nx   = rbin + PW'(rd_pull);
    assign rgray_nx  = bin2gray(rbin_nx);

`ifdef FIFO_FWFT_EN
    logic ov, ov_nx;
    // Refill the output register whenever it is empty or being popped this cycle.
    assign rd_pull  = !ram_empty && (!ov || rd_en);
    assign ov_nx    = rd_pull || (ov && !rd_en);
    assign empty    = !ov;
    assign rd_count = wsync_bin - rbin + PW'(ov);
    assign rcnt_nx  = wsync_bin - rbin_nx + PW'(ov_nx);

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) ov <= 1'b0;
        else     ov <= ov_nx;
    end
`else
    assign rd_pull  = rd_en && !ram_empty;
    assign empty    = ram_empty;
    assign rd_count = wsync_bin - rbin;
    assign rcnt_nx  = wsync_bin - rbin_nx;
`endif

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            wsync_q      <= '0;
            rbin         <= '0;
            rgray        <= '0;
            ram_empty    <= 1'b1;
            almost_empty <= 1'b1;
            underflow    <= 1'b0;
            rdata        <= '0;
        end else begin
            wsync_q      <= {wsync_q[SYNC_STAGES-2:0], wgray};
            rbin         <= rbin_nx;
            rgray        <= rgray_nx;
            ram_empty    <= (rgray_nx == wgray_r);
            almost_empty <= (rcnt_nx <= PW'(AEMPTY_TH));
            underflow    <= rd_en && empty;
            if (rd_pull) rdata <= mem[rbin[ADDR_W-1:0]];
        end
    end
endmodule

// File: tb/tb_async_fifo_gray.sv
// Directed bench for async_fifo_gray: fill/overflow, drain/underflow, clocked traffic, mid-run reset.
`timescale 1ns/1ps
module tb_async_fifo_gray;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int SYNC   = 2;

    logic              wclk = 1'b0;
    logic              rclk = 1'b0;
    logic              rst;
    logic              wr_en, rd_en;
    logic [DATA_W-1:0] wdata, rdata;
    logic              full, almost_full, overflow;
    logic              empty, almost_empty, underflow;
    logic [ADDR_W:0]   wr_count, rd_count;

    int  total = 0;
    int  bad   = 0;
    real rhalf = 13.5;

    always #5 wclk = ~wclk;
    always #(rhalf) rclk = ~rclk;

    async_fifo_gray #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC),
                      .AFULL_TH(6), .AEMPTY_TH(1)) dut (
        .wclk(wclk), .rclk(rclk), .rst(rst),
        .wr_en(wr_en), .wdata(wdata), .full(full), .almost_full(almost_full),
        .wr_count(wr_count), .overflow(overflow),
        .rd_en(rd_en), .rdata(rdata), .empty(empty), .almost_empty(almost_empty),
        .rd_count(rd_count), .underflow(underflow)
    );

    logic [DATA_W-1:0] q[$];

    task automatic test_reset;
        total++; if (empty !== 1'b1)        begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0)         begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL rst_aempty got=%b exp=1", almost_empty); end
        total++; if (almost_full !== 1'b0)  begin bad++; $display("FAIL rst_afull got=%b exp=0", almost_full); end
        total++; if (wr_count !== 4'd0)     begin bad++; $display("FAIL rst_wcnt got=%0d exp=0", wr_count); end
        total++; if (rd_count !== 4'd0)     begin bad++; $display("FAIL rst_rcnt got=%0d exp=0", rd_count); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin bad++; $display("FAIL rst_ovf_udf got=%b%b exp=00", overflow, underflow); end
        total++; if (rdata !== 16'h0)       begin bad++; $display("FAIL rst_rdata got=%h exp=0000", rdata); end
    endtask

    task automatic test_fill;
        @(posedge wclk); #1;
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wdata = 16'(i);
            @(posedge wclk); #1;
            total++; if (wr_count !== 4'(i))
                begin bad++; $display("FAIL fill_wcnt[%0d] got=%0d exp=%0d", i, wr_count, i); end
            total++; if (almost_full !== (i >= 6))
                begin bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almost_full, i >= 6); end
            total++; if (full !== (i == 8))
                begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 8); end
        end
        wdata = 16'h0009;
        @(posedge wclk); #1;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
        total++; if (wr_count !== 4'd8) begin bad++; $display("FAIL ovf_wcnt got=%0d exp=8", wr_count); end
        wr_en = 1'b0;
        @(posedge wclk); #1;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_drain;
        repeat (SYNC + 3) @(posedge rclk);
        #1;
        total++; if (empty !== 1'b0)        begin bad++; $display("FAIL drain_notempty got=%b exp=0", empty); end
        total++; if (rd_count !== 4'd8)     begin bad++; $display("FAIL drain_rcnt got=%0d exp=8", rd_count); end
        total++; if (almost_empty !== 1'b0) begin bad++; $display("FAIL drain_aempty got=%b exp=0", almost_empty); end
        rd_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge rclk); #1;
            total++; if (rdata !== 16'(k))
                begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", k, rdata, 16'(k)); end
            total++; if (empty !== (k == 8))
                begin bad++; $display("FAIL drain_empty[%0d] got=%b exp=%b", k, empty, k == 8); end
        end
        @(posedge rclk); #1;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_pulse got=%b exp=1", underflow); end
        total++; if (rdata !== 16'h0008) begin bad++; $display("FAIL udf_rdata got=%h exp=0008", rdata); end
        rd_en = 1'b0;
        @(posedge rclk); #1;
        total++; if (underflow !== 1'b0)    begin bad++; $display("FAIL udf_clear got=%b exp=0", underflow); end
        total++; if (rd_count !== 4'd0)     begin bad++; $display("FAIL udf_rcnt got=%0d exp=0", rd_count); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL udf_aempty got=%b exp=1", almost_empty); end
    endtask

    // Flag-respecting producer and consumer with a scoreboard queue.
    task automatic test_traffic(input int n, input int wpct, input int rpct, input int bound);
        int  sent = 0, got = 0;
        bit  ovf = 0, udf = 0, cnt_hi = 0;
        q.delete();
        fork
            begin
                int cyc = 0;
                @(posedge wclk); #1;
                while (sent < n && cyc < bound) begin
                    if (!full && $urandom_range(99) < wpct) begin
                        wr_en = 1'b1; wdata = 16'($urandom);
                        q.push_back(wdata); sent++;
                    end else wr_en = 1'b0;
                    @(posedge wclk); #1;
                    if (overflow) ovf = 1;
                    if (wr_count > 4'd8) cnt_hi = 1;
                    cyc++;
                end
                wr_en = 1'b0;
            end
            begin
                int  cyc = 0;
                bit  pend;
                logic [DATA_W-1:0] exp;
                @(posedge rclk); #1;
                while (got < n && cyc < bound) begin
                    pend  = !empty && ($urandom_range(99) < rpct);
                    rd_en = pend;
                    @(posedge rclk); #1;
                    if (underflow) udf = 1;
                    if (rd_count > 4'd8) cnt_hi = 1;
                    if (pend) begin
                        total++;
                        if (q.size() == 0) begin
                            bad++; $display("FAIL traffic_extra got=%h exp=none", rdata);
                        end else begin
                            exp = q.pop_front();
                            if (rdata !== exp) begin
                                bad++; $display("FAIL traffic_data[%0d] got=%h exp=%h", got, rdata, exp);
                            end
                        end
                        got++;
                    end
                    cyc++;
                end
                rd_en = 1'b0;
            end
        join
        total++; if (got !== n)   begin bad++; $display("FAIL traffic_done got=%0d exp=%0d", got, n); end
        total++; if (ovf)         begin bad++; $display("FAIL traffic_ovf got=1 exp=0"); end
        total++; if (udf)         begin bad++; $display("FAIL traffic_udf got=1 exp=0"); end
        total++; if (cnt_hi)      begin bad++; $display("FAIL traffic_count got=>8 exp=<=8"); end
        total++; if (q.size() != 0) begin bad++; $display("FAIL traffic_left got=%0d exp=0", q.size()); end
    endtask

    task automatic test_reset_mid;
        @(posedge wclk); #1;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = 16'h0A00 + 16'(i);
            @(posedge wclk); #1;
        end
        wr_en = 1'b0;
        repeat (SYNC + 3) @(posedge rclk);
        #1;
        total++; if (wr_count !== 4'd5) begin bad++; $display("FAIL mid_pre_wcnt got=%0d exp=5", wr_count); end
        total++; if (empty !== 1'b0)    begin bad++; $display("FAIL mid_pre_empty got=%b exp=0", empty); end
        @(posedge wclk); #2;
        rst = 1'b1;
        #1;
        total++; if (empty !== 1'b1)    begin bad++; $display("FAIL mid_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0)     begin bad++; $display("FAIL mid_full got=%b exp=0", full); end
        total++; if (wr_count !== 4'd0) begin bad++; $display("FAIL mid_wcnt got=%0d exp=0", wr_count); end
        total++; if (rd_count !== 4'd0) begin bad++; $display("FAIL mid_rcnt got=%0d exp=0", rd_count); end
        @(posedge wclk); #3;
        rst = 1'b0;
        repeat (SYNC + 2) @(posedge rclk);
        @(posedge wclk); #1;
        wr_en = 1'b1; wdata = 16'hBEEF;
        @(posedge wclk); #1;
        wr_en = 1'b0;
        repeat (SYNC + 3) @(posedge rclk);
        #1;
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL mid_post_empty got=%b exp=0", empty); end
        rd_en = 1'b1;
        @(posedge rclk); #1;
        rd_en = 1'b0;
        total++; if (rdata !== 16'hBEEF) begin bad++; $display("FAIL mid_beef got=%h exp=beef", rdata); end
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL mid_beef_empty got=%b exp=1", empty); end
    endtask

    task automatic test_fwft;
        @(posedge wclk); #1;
        wr_en = 1'b1; wdata = 16'h1234;
        @(posedge wclk); #1;
        wr_en = 1'b0;
        repeat (SYNC + 4) @(posedge rclk);
        #1;
        total++; if (empty !== 1'b0)     begin bad++; $display("FAIL fwft_empty got=%b exp=0", empty); end
        total++; if (rdata !== 16'h1234) begin bad++; $display("FAIL fwft_rdata got=%h exp=1234", rdata); end
        total++; if (rd_count !== 4'd1)  begin bad++; $display("FAIL fwft_rcnt got=%0d exp=1", rd_count); end
        rd_en = 1'b1;
        @(posedge rclk); #1;
        rd_en = 1'b0;
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL fwft_pop_empty got=%b exp=1", empty); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL fwft_udf got=%b exp=0", underflow); end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
        #40;
        test_reset;
        @(posedge wclk); #3;
        rst = 1'b0;
        repeat (SYNC + 2) @(posedge rclk);
`ifdef FIFO_FWFT_EN
        test_fwft;
`else
        test_fill;
        test_drain;
        test_traffic(2000, 50, 50, 40000);
        rhalf = 5.0;
        repeat (4) @(posedge rclk);
        test_traffic(64, 100, 100, 2000);
        rhalf = 13.5;
        repeat (4) @(posedge rclk);
        test_reset_mid;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
